cordic_iter: RTL



---
 rtl/cordic_iter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cordic_iter.sv
// rtl/cordic_iter.sv - iterative CORDIC rotation/vectoring engine, one micro-rotation per clock
// Optional quadrant pre-rotation in the load cycle: define CORDIC_QUAD_EXT_EN.
`timescale 1ns/1ps
module cordic_iter #(
   parameter int DATA_W = 16,
   parameter int ANG_W  = 19,
   parameter int ITER   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     mode,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] y_in,
   input  logic signed [ANG_W-1:0]  z_in,
   output logic                     busy,
   output logic                     done,
   output logic signed [DATA_W+1:0] x_out,
   output logic signed [DATA_W+1:0] y_out,
   output logic signed [ANG_W-1:0]  z_out
);

   localparam int XW   = DATA_W + 2;
   localparam int FRAC = ANG_W - 3;
   localparam int RSH  = 32 - FRAC;
   localparam int IW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [IW-1:0] LAST_I = IW'(ITER - 1);

   // atan(2^-i) at 32 fractional bits, rounded to nearest
   function automatic logic [31:0] atan32(input int i);
      case (i)
         0:       atan32 = 32'hC90FDAA2;
         1:       atan32 = 32'd1991351318;
         2:       atan32 = 32'd1052175346;
         3:       atan32 = 32'd534100635;
         4:       atan32 = 32'd268086748;
         5:       atan32 = 32'd134174063;
         6:       atan32 = 32'd67103403;
         7:       atan32 = 32'd33553749;
         8:       atan32 = 32'd16777131;
         9:       atan32 = 32'd8388597;
         10:      atan32 = 32'd4194303;
         default: atan32 = 32'd1 << (32 - i);
      endcase
   endfunction

   function automatic logic signed [ANG_W-1:0] round_frac(input logic [63:0] v32);
      logic [63:0] t;
      t = ((v32 << 1) >> RSH) + 64'd1;
      t = t >> 1;
      round_frac = t[ANG_W-1:0];
   endfunction

`ifdef CORDIC_QUAD_EXT_EN
   localparam logic signed [ANG_W-1:0] HALF_PI = round_frac(64'd6746518852);
   localparam logic signed [ANG_W-1:0] PI      = round_frac(64'd13493037705);
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
   logic signed [ANG_W-1:0] z_q, z_d;
   logic                    mode_q, mode_d;
   logic [IW-1:0]           i_q, i_d;
   logic                    done_q, done_d;
   logic signed [XW-1:0]    x_out_q, x_out_d, y_out_q, y_out_d;
   logic signed [ANG_W-1:0] z_out_q, z_out_d;

   logic signed [ANG_W-1:0] atan_tab [ITER];
   for (genvar g = 0; g < ITER; g++) begin : g_atan
      assign atan_tab[g] = round_frac({32'd0, atan32(g)});
   end

   logic signed [XW-1:0]    x_ext, y_ext, x_sh, y_sh, x_it, y_it;
   logic signed [ANG_W-1:0] z_it;
   logic                    d_pos;

   assign x_ext = {{2{x_in[DATA_W-1]}}, x_in};
   assign y_ext = {{2{y_in[DATA_W-1]}}, y_in};

   // d = +1: rotation when z >= 0, vectoring when y < 0
   assign d_pos = mode_q ? y_q[XW-1] : ~z_q[ANG_W-1];
   assign x_sh  = x_q >>> i_q;
   assign y_sh  = y_q >>> i_q;
   assign x_it  = d_pos ? x_q - y_sh : x_q + y_sh;
   assign y_it  = d_pos ? y_q + x_sh : y_q - x_sh;
   assign z_it  = d_pos ? z_q - atan_tab[i_q] : z_q + atan_tab[i_q];

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      mode_d  = mode_q;
      i_d     = i_q;
      done_d  = 1'b0;
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      z_out_d = z_out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               i_d     = '0;
               state_d = S_RUN;
               x_d     = x_ext;
               y_d     = y_ext;
               z_d     = z_in;
`ifdef CORDIC_QUAD_EXT_EN
               if (!mode) begin
                  if (z_in > HALF_PI) begin
                     x_d = -y_ext;
                     y_d = x_ext;
                     z_d = z_in - HALF_PI;
                  end else if (z_in < -HALF_PI) begin
                     x_d = y_ext;
                     y_d = -x_ext;
                     z_d = z_in + HALF_PI;
                  end
               end else if (x_in[DATA_W-1]) begin
                  x_d = -x_ext;
                  y_d = -y_ext;
                  z_d = y_in[DATA_W-1] ? z_in - PI : z_in + PI;
               end
`endif
            end
         end
         S_RUN: begin
            x_d = x_it;
            y_d = y_it;
            z_d = z_it;
            if (i_q == LAST_I) state_d = S_DONE;
            else               i_d     = i_q + 1'b1;
         end
         S_DONE: begin
            x_out_d = x_q;
            y_out_d = y_q;
            z_out_d = z_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         mode_q  <= 1'b0;
         i_q     <= '0;
         done_q  <= 1'b0;
         x_out_q <= '0;
         y_out_q <= '0;
         z_out_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         mode_q  <= mode_d;
         i_q     <= i_d;
         done_q  <= done_d;
         x_out_q <= x_out_d;
         y_out_q <= y_out_d;
         z_out_q <= z_out_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign done  = done_q;
   assign x_out = x_out_q;
   assign y_out = y_out_q;
   assign z_out = z_out_q;

endmodule
